dma_pack_buffer: RTL and testbench

DMA_PACK_BUFFER -- requirements
Module: dma_pack_buffer

---
 rtl/dma_pkg.sv | 19 +
 rtl/dma_line_fifo.sv | 72 +++++++
 rtl/dma_pack_buffer.sv | 105 ++++++++++
 tb/tb_dma_pack_buffer.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/dma_pkg.sv
// Shared DMA parameters and the pack-buffer assembler state type.
// The control and address blocks take their widths from here as well.
package dma_pkg;

    localparam int SDRAM_W    = 64;   // width of one SDRAM read beat
    localparam int MEM_W      = 256;  // width of one packed memory line
    localparam int BEATS      = 4;    // beats per line (MEM_W / SDRAM_W)
    localparam int LINE_DEPTH = 2;    // lines held by the line FIFO
    localparam int CNT_W      = 2;    // width of beat and line counters

    // Assembler state: the state index equals the number of beats held.
    typedef enum logic [1:0] {
        FILL0 = 2'd0,
        FILL1 = 2'd1,
        FILL2 = 2'd2,
        FILL3 = 2'd3
    } fill_state_e;

endpackage

// File: rtl/dma_line_fifo.sv
// Two-entry FIFO of packed lines with a combinational head.
// Storage is never reset; only pointers and count are, and the consumer
// masks the head with the count.
module dma_line_fifo
    import dma_pkg::*;
(
    input  logic               clk_h,
    input  logic               rst_n,
    input  logic               clear,
    input  logic               push,
    input  logic               pop,
    input  logic [MEM_W-1:0]   din,
    output logic [MEM_W-1:0]   head,
    output logic [CNT_W-1:0]   count
);

    logic [MEM_W-1:0] mem_q [LINE_DEPTH];
    logic             wr_ptr_q, wr_ptr_d;
    logic             rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             do_pop;
    logic             do_push;

    // A pop of an empty FIFO is ignored. A push into a full FIFO is only
    // taken when a pop frees a slot in the same cycle.
    assign do_pop  = pop && (count_q != '0);
    assign do_push = push && ((count_q < CNT_W'(LINE_DEPTH)) || do_pop);

    // Next pointer and occupancy; pointers wrap modulo 2 by their width.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (clear) begin
            wr_ptr_d = 1'b0;
            rd_ptr_d = 1'b0;
            count_d  = '0;
        end else begin
            if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
            if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
            if (do_push && !do_pop)      count_d = count_q + 1'b1;
            else if (do_pop && !do_push) count_d = count_q - 1'b1;
        end
    end

    // Pointer and count registers.
    always_ff @(posedge clk_h) begin
        if (!rst_n) begin
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Line storage, one write port per entry; contents survive reset.
    for (genvar gi = 0; gi < LINE_DEPTH; gi++) begin : g_entry
        // Capture the incoming line into this entry when it is the write target.
        always_ff @(posedge clk_h) begin
            if (do_push && !clear && (wr_ptr_q == 1'(gi))) begin
                mem_q[gi] <= din;
            end
        end
    end

    assign head  = mem_q[rd_ptr_q];
    assign count = count_q;

endmodule

// File: rtl/dma_pack_buffer.sv
// Packs 64-bit SDRAM read beats into 256-bit memory lines. Beats collect in
// an assembler (first beat in the low bits); the fourth beat completes the
// line, which is pushed straight into a two-entry line FIFO.
module dma_pack_buffer
    import dma_pkg::*;
(
    input  logic               clk_h,
    input  logic               rst_n,
    input  logic               clear_data,
    input  logic               sdram_valid,
    input  logic [SDRAM_W-1:0] sdram_data,
    output logic               read_ready,
    output logic               write_ready,
    output logic [MEM_W-1:0]   data_to_memory,
    input  logic               pop,
    output logic [CNT_W-1:0]   beat_cnt,
    output logic [CNT_W-1:0]   line_count,
    output logic               overflow
);

    fill_state_e      state_q, state_d;
    logic             overflow_q, overflow_d;
    logic [SDRAM_W-1:0] asm_q [BEATS-1];
    logic [MEM_W-1:0] line_w;
    logic [MEM_W-1:0] head_w;
    logic             accept;
    logic             drop;
    logic             push;
    logic             pop_ok;

    // Stall only when the FIFO is full and the next beat would complete a
    // line; pop is deliberately kept off this path.
    assign read_ready = (line_count < CNT_W'(LINE_DEPTH)) || (beat_cnt != 2'd3);
    assign accept     = sdram_valid && read_ready && !clear_data;
    assign drop       = sdram_valid && !read_ready;
    assign pop_ok     = pop && write_ready && !clear_data;

    // Assembler state register.
    always_ff @(posedge clk_h) begin
        if (!rst_n) state_q <= FILL0;
        else        state_q <= state_d;
    end

    // Assembler next state: advance one slot per accepted beat, flush on clear.
    always_comb begin
        state_d = state_q;
        if (clear_data) begin
            state_d = FILL0;
        end else if (accept) begin
            case (state_q)
                FILL0:   state_d = FILL1;
                FILL1:   state_d = FILL2;
                FILL2:   state_d = FILL3;
                default: state_d = FILL0;
            endcase
        end
    end

    // Assembler outputs: beat count is the state index; the last slot pushes.
    always_comb begin
        beat_cnt = state_q;
        push     = accept && (state_q == FILL3);
    end

    // Hold the first BEATS-1 beats; the final beat goes straight into the line.
    for (genvar gi = 0; gi < BEATS - 1; gi++) begin : g_slot
        // Capture a beat into this slot when the assembler is at this index.
        always_ff @(posedge clk_h) begin
            if (accept && (state_q == fill_state_e'(gi))) begin
                asm_q[gi] <= sdram_data;
            end
        end
        assign line_w[gi*SDRAM_W +: SDRAM_W] = asm_q[gi];
    end
    assign line_w[(BEATS-1)*SDRAM_W +: SDRAM_W] = sdram_data;

    // Sticky drop flag, cleared only by reset or flush.
    always_comb begin
        overflow_d = overflow_q | drop;
        if (clear_data) overflow_d = 1'b0;
    end

    // Overflow register.
    always_ff @(posedge clk_h) begin
        if (!rst_n) overflow_q <= 1'b0;
        else        overflow_q <= overflow_d;
    end

    dma_line_fifo u_line_fifo (
        .clk_h (clk_h),
        .rst_n (rst_n),
        .clear (clear_data),
        .push  (push),
        .pop   (pop_ok),
        .din   (line_w),
        .head  (head_w),
        .count (line_count)
    );

    // Line storage is not reset, so the head is masked when the FIFO is empty.
    assign write_ready    = (line_count != '0);
    assign data_to_memory = write_ready ? head_w : '0;
    assign overflow       = overflow_q;

endmodule

// File: tb/tb_dma_pack_buffer.sv
// Self-checking bench for dma_pack_buffer: directed scenarios plus a random
// run, all compared against a queue-based model of beats and lines.
module tb_dma_pack_buffer;

    logic         clk_h;
    logic         rst_n;
    logic         clear_data;
    logic         sdram_valid;
    logic [63:0]  sdram_data;
    logic         read_ready;
    logic         write_ready;
    logic [255:0] data_to_memory;
    logic         pop;
    logic [1:0]   beat_cnt;
    logic [1:0]   line_count;
    logic         overflow;

    int errors = 0;
    int checks = 0;

    // Reference model: partial beats, complete lines, sticky drop flag.
    logic [63:0]  m_beats [$];
    logic [255:0] m_lines [$];
    logic         m_ovf;

    dma_pack_buffer dut (
        .clk_h          (clk_h),
        .rst_n          (rst_n),
        .clear_data     (clear_data),
        .sdram_valid    (sdram_valid),
        .sdram_data     (sdram_data),
        .read_ready     (read_ready),
        .write_ready    (write_ready),
        .data_to_memory (data_to_memory),
        .pop            (pop),
        .beat_cnt       (beat_cnt),
        .line_count     (line_count),
        .overflow       (overflow)
    );

    initial clk_h = 1'b0;
    always #5 clk_h = ~clk_h;

    function automatic logic [255:0] m_head();
        return (m_lines.size() != 0) ? m_lines[0] : 256'b0;
    endfunction

    function automatic logic m_ready();
        return (m_lines.size() < 2) || (m_beats.size() != 3);
    endfunction

    task automatic model_step(input logic v, input logic [63:0] d, input logic p,
                              input logic c, input logic r);
        logic rr;
        if (!r || c) begin
            m_beats.delete();
            m_lines.delete();
            m_ovf = 1'b0;
        end else begin
            rr = m_ready();
            if (p && m_lines.size() != 0) void'(m_lines.pop_front());
            if (v && rr) begin
                m_beats.push_back(d);
                if (m_beats.size() == 4) begin
                    m_lines.push_back({m_beats[3], m_beats[2], m_beats[1], m_beats[0]});
                    m_beats.delete();
                end
            end else if (v) begin
                m_ovf = 1'b1;
            end
        end
    endtask

    // One clock: apply inputs, advance the model, return 1 ns after the edge.
    task automatic drive(input logic v, input logic [63:0] d, input logic p,
                         input logic c, input logic r);
        sdram_valid = v; sdram_data = d; pop = p; clear_data = c; rst_n = r;
        model_step(v, d, p, c, r);
        @(posedge clk_h); #1;
        sdram_valid = 1'b0; pop = 1'b0; clear_data = 1'b0; rst_n = 1'b1;
    endtask

    task automatic beat(input logic [63:0] d);
        drive(1'b1, d, 1'b0, 1'b0, 1'b1);
    endtask

    task automatic do_reset();
        drive(1'b0, 64'h0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic test_reset();
        drive(1'b1, 64'hDEAD_BEEF_0000_0001, 1'b1, 1'b0, 1'b0);
        do_reset();
        checks++; if (beat_cnt !== 2'd0) begin errors++; $display("FAIL reset_beat_cnt: got %0d want 0", beat_cnt); end
        checks++; if (line_count !== 2'd0) begin errors++; $display("FAIL reset_line_count: got %0d want 0", line_count); end
        checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL reset_overflow: got %b want 0", overflow); end
        checks++; if (write_ready !== 1'b0) begin errors++; $display("FAIL reset_write_ready: got %b want 0", write_ready); end
        checks++; if (data_to_memory !== 256'b0) begin errors++; $display("FAIL reset_data: got %h want 0", data_to_memory); end
        checks++; if (read_ready !== 1'b1) begin errors++; $display("FAIL reset_read_ready: got %b want 1", read_ready); end
        $display("reset: beat_cnt=%0d line_count=%0d read_ready=%b", beat_cnt, line_count, read_ready);
    endtask

    task automatic test_single_line();
        logic [255:0] want;
        want = {64'h4444444444444444, 64'h3333333333333333,
                64'h2222222222222222, 64'h1111111111111111};
        do_reset();
        beat(64'h1111111111111111);
        beat(64'h2222222222222222);
        beat(64'h3333333333333333);
        checks++; if (write_ready !== 1'b0) begin errors++; $display("FAIL line_early_wr: got %b want 0", write_ready); end
        checks++; if (beat_cnt !== 2'd3) begin errors++; $display("FAIL line_beat_cnt3: got %0d want 3", beat_cnt); end
        beat(64'h4444444444444444);
        checks++; if (write_ready !== 1'b1) begin errors++; $display("FAIL line_write_ready: got %b want 1", write_ready); end
        checks++; if (data_to_memory !== want) begin errors++; $display("FAIL line_data: got %h want %h", data_to_memory, want); end
        checks++; if (beat_cnt !== 2'd0) begin errors++; $display("FAIL line_beat_cnt0: got %0d want 0", beat_cnt); end
        $display("single_line: write_ready=%b data=%h", write_ready, data_to_memory);
    endtask

    task automatic test_fill_overflow();
        do_reset();
        for (int i = 0; i < 8; i++) beat({32'hA000_0000 + 32'(i), $urandom});
        checks++; if (line_count !== 2'd2) begin errors++; $display("FAIL fill_line_count: got %0d want 2", line_count); end
        for (int i = 0; i < 3; i++) beat({32'hB000_0000 + 32'(i), $urandom});
        checks++; if (beat_cnt !== 2'd3) begin errors++; $display("FAIL fill_beat_cnt: got %0d want 3", beat_cnt); end
        checks++; if (read_ready !== 1'b0) begin errors++; $display("FAIL fill_read_ready: got %b want 0", read_ready); end
        checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL fill_early_ovf: got %b want 0", overflow); end
        beat(64'hCCCC_CCCC_CCCC_CCCC);
        checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL drop_overflow: got %b want 1", overflow); end
        checks++; if (beat_cnt !== 2'd3) begin errors++; $display("FAIL drop_beat_cnt: got %0d want 3", beat_cnt); end
        checks++; if (data_to_memory !== m_head()) begin errors++; $display("FAIL drop_head: got %h want %h", data_to_memory, m_head()); end
        // Popping frees a slot; the sticky flag must survive it.
        drive(1'b0, 64'h0, 1'b1, 1'b0, 1'b1);
        checks++; if (overflow !== 1'b1 || line_count !== 2'd1 || data_to_memory !== m_head()) begin
            errors++; $display("FAIL pop_after_full: got ovf=%b cnt=%0d head=%h want ovf=1 cnt=1 head=%h",
                               overflow, line_count, data_to_memory, m_head());
        end
        $display("fill_overflow: line_count=%0d overflow=%b", line_count, overflow);
    endtask

    task automatic test_push_pop();
        do_reset();
        for (int i = 0; i < 7; i++) beat({$urandom, $urandom});
        drive(1'b1, 64'h5555_6666_7777_8888, 1'b1, 1'b0, 1'b1);
        checks++; if (line_count !== 2'd1) begin errors++; $display("FAIL pushpop_count: got %0d want 1", line_count); end
        checks++; if (data_to_memory !== m_head() || data_to_memory[255:192] !== 64'h5555_6666_7777_8888) begin
            errors++; $display("FAIL pushpop_head: got %h want %h", data_to_memory, m_head());
        end
        $display("push_pop: line_count=%0d head=%h", line_count, data_to_memory);
    endtask

    task automatic test_pop_empty();
        do_reset();
        beat(64'h0123_4567_89AB_CDEF);
        drive(1'b0, 64'h0, 1'b1, 1'b0, 1'b1);
        checks++; if (line_count !== 2'd0 || write_ready !== 1'b0) begin
            errors++; $display("FAIL pop_empty_state: got cnt=%0d wr=%b want cnt=0 wr=0", line_count, write_ready);
        end
        checks++; if (data_to_memory !== 256'b0) begin errors++; $display("FAIL pop_empty_data: got %h want 0", data_to_memory); end
        checks++; if (beat_cnt !== 2'd1) begin errors++; $display("FAIL pop_empty_beat: got %0d want 1", beat_cnt); end
        $display("pop_empty: line_count=%0d write_ready=%b", line_count, write_ready);
    endtask

    task automatic test_clear();
        do_reset();
        for (int i = 0; i < 6; i++) beat({$urandom, $urandom});
        checks++; if (beat_cnt !== 2'd2 || line_count !== 2'd1) begin
            errors++; $display("FAIL clear_setup: got beat=%0d cnt=%0d want beat=2 cnt=1", beat_cnt, line_count);
        end
        drive(1'b1, 64'hFFFF_0000_FFFF_0000, 1'b1, 1'b1, 1'b1);
        checks++; if (beat_cnt !== 2'd0 || line_count !== 2'd0 || overflow !== 1'b0) begin
            errors++; $display("FAIL clear_state: got beat=%0d cnt=%0d ovf=%b want 0 0 0", beat_cnt, line_count, overflow);
        end
        checks++; if (write_ready !== 1'b0 || data_to_memory !== 256'b0) begin
            errors++; $display("FAIL clear_outputs: got wr=%b data=%h want wr=0 data=0", write_ready, data_to_memory);
        end
        $display("clear: beat_cnt=%0d line_count=%0d overflow=%b", beat_cnt, line_count, overflow);
    endtask

    task automatic test_reset_mid();
        logic [63:0] b [4];
        do_reset();
        for (int i = 0; i < 7; i++) beat({$urandom, $urandom});
        drive(1'b1, 64'h9999_9999_9999_9999, 1'b0, 1'b0, 1'b0);
        checks++; if (beat_cnt !== 2'd0 || line_count !== 2'd0 || overflow !== 1'b0 ||
                      write_ready !== 1'b0 || data_to_memory !== 256'b0 || read_ready !== 1'b1) begin
            errors++; $display("FAIL reset_mid: got beat=%0d cnt=%0d ovf=%b wr=%b rr=%b data=%h want 0 0 0 0 1 0",
                               beat_cnt, line_count, overflow, write_ready, read_ready, data_to_memory);
        end
        for (int i = 0; i < 4; i++) begin
            b[i] = {$urandom, $urandom};
            beat(b[i]);
        end
        checks++; if (line_count !== 2'd1 || data_to_memory !== {b[3], b[2], b[1], b[0]}) begin
            errors++; $display("FAIL reset_mid_line: got cnt=%0d data=%h want cnt=1 data=%h",
                               line_count, data_to_memory, {b[3], b[2], b[1], b[0]});
        end
        $display("reset_mid: line=%h", data_to_memory);
    endtask

    task automatic test_random();
        logic v, p, c, r;
        int bad;
        do_reset();
        for (int n = 0; n < 400; n++) begin
            v = ($urandom_range(0, 99) < 70);
            p = ($urandom_range(0, 99) < ((n % 100) < 50 ? 10 : 45));
            c = ($urandom_range(0, 99) < 2);
            r = ($urandom_range(0, 99) >= 1);
            drive(v, {$urandom, $urandom}, p, c, r);
            bad = 0;
            checks++;
            if (beat_cnt !== 2'(m_beats.size()) || line_count !== 2'(m_lines.size()) ||
                overflow !== m_ovf || write_ready !== (m_lines.size() != 0) ||
                read_ready !== m_ready() || data_to_memory !== m_head()) begin
                errors++; bad = 1;
                $display("FAIL random_%0d: got beat=%0d cnt=%0d ovf=%b wr=%b rr=%b head=%h want beat=%0d cnt=%0d ovf=%b rr=%b head=%h",
                         n, beat_cnt, line_count, overflow, write_ready, read_ready, data_to_memory,
                         m_beats.size(), m_lines.size(), m_ovf, m_ready(), m_head());
            end
            $display("random %0d: v=%b p=%b c=%b r=%b beat=%0d cnt=%0d ovf=%b ok=%0d",
                     n, v, p, c, r, beat_cnt, line_count, overflow, !bad);
        end
    endtask

    initial begin
        rst_n = 1'b0; clear_data = 1'b0; sdram_valid = 1'b0;
        sdram_data = 64'h0; pop = 1'b0;
        m_ovf = 1'b0;
        test_reset();
        test_single_line();
        test_fill_overflow();
        test_push_pop();
        test_pop_empty();
        test_clear();
        test_reset_mid();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
